fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set PC/address width.
REQ-002 Parameter RESET_PC, default 0, SHALL set PC value after reset.
REQ-003 Parameter PC_INC, default 1, SHALL set sequential PC step (word addressing).
REQ-004 Parameter IRQ_VECTOR, default 32'h0000_0040, SHALL set interrupt target (used only under FETCH_SEQ_IRQ_EN).
REQ-005 Ports: CLK in 1 (sole clock, rising edge); RST_N in 1 (asynchronous, active-low reset).
REQ-006 Ports: HLT in 1 (halt request, level); BR_TAKEN in 1 (redirect strobe); BR_TARGET in ADDR_W (redirect address).
REQ-007 Ports: IMEM_REQ out 1; IMEM_ADDR out ADDR_W; IMEM_GNT in 1; IMEM_RVALID in 1; IMEM_RDATA in 32.
REQ-008 Ports: INSTR_VALID out 1; INSTR out 32; INSTR_PC out ADDR_W; PC_OUT out ADDR_W; HALTED out 1.
REQ-009 Ports under FETCH_SEQ_IRQ_EN only: IRQ in 1 (level); IRQ_ACK out 1; EPC out ADDR_W.

Function
REQ-010 FSM states SHALL be IDLE, REQ, WAIT, HALT; exactly one outstanding memory transaction maximum.
REQ-011 IDLE SHALL last one cycle after reset release, then go to REQ.
REQ-012 REQ: IMEM_REQ=1, IMEM_ADDR=PC_OUT; IMEM_GNT=1 SHALL move to WAIT; else hold REQ with stable address.
REQ-013 WAIT: IMEM_RVALID=1 SHALL pulse INSTR_VALID one cycle next edge with INSTR=IMEM_RDATA, INSTR_PC=fetched PC, and PC_OUT<=PC_OUT+PC_INC modulo 2^ADDR_W.
REQ-014 After WAIT completes, next state SHALL be HALT if HLT=1, else REQ; best case one instruction per 2 cycles.
REQ-015 BR_TAKEN in REQ without GNT: PC_OUT<=BR_TARGET, stay REQ, no memory side effect.
REQ-016 BR_TAKEN in REQ with GNT same cycle, or in WAIT: PC_OUT<=BR_TARGET, set drop flag; the pending response SHALL be consumed with INSTR_VALID suppressed, then REQ at new PC.
REQ-017 BR_TAKEN coinciding with IMEM_RVALID in WAIT: response dropped, PC_OUT=BR_TARGET (not +PC_INC).
REQ-018 Priority: reset > BR_TAKEN > IRQ > HLT > sequential increment.
REQ-019 HLT=1 in REQ before grant SHALL go HALT directly, IMEM_REQ deasserted; in WAIT halt SHALL wait for response.
REQ-020 HALT: HALTED=1, IMEM_REQ=0, PC_OUT held; BR_TAKEN ignored; HLT=0 SHALL return to REQ next cycle.
REQ-021 INSTR and INSTR_PC SHALL hold last value while INSTR_VALID=0.

Reset
REQ-022 RST_N=0 SHALL asynchronously force state IDLE, PC_OUT=RESET_PC, IMEM_REQ=0, INSTR_VALID=0, INSTR=0, INSTR_PC=0, HALTED=0, drop flag=0, IRQ_ACK=0, EPC=0.
REQ-023 Reset mid-WAIT SHALL abandon the transaction; late IMEM_RVALID in IDLE/REQ SHALL be ignored.

Configuration
REQ-024 With FETCH_SEQ_IRQ_EN defined: IRQ=1 in REQ before grant, no BR_TAKEN, SHALL set EPC<=PC_OUT, PC_OUT<=IRQ_VECTOR, pulse IRQ_ACK one cycle, stay REQ.
REQ-025 IRQ SHALL not be taken in WAIT, HALT or IDLE; it is evaluated at next REQ.
REQ-026 Without FETCH_SEQ_IRQ_EN: IRQ, IRQ_ACK, EPC ports and logic absent; behaviour otherwise identical.

Structure
REQ-027 Shared package fetch_seq_pkg SHALL hold the state encoding (IDLE=0, REQ=1, WAIT=2, HALT=3) and default RESET_PC/PC_INC/IRQ_VECTOR constants.
REQ-028 Sub-module fetch_pc_reg SHALL hold the PC register with async reset, load and increment enables.

Verification
REQ-029 Reset release, GNT=1 always, RVALID one cycle after grant, RDATA=0xA0,0xA1,0xA2 -> INSTR_VALID pulses, INSTR_PC=0,1,2, PC_OUT=3.
REQ-030 BR_TAKEN=1, BR_TARGET=0x100 in WAIT for PC=5 -> fetch at 5 dropped (no INSTR_VALID), next IMEM_ADDR=0x100.
REQ-031 HLT=1 in WAIT at PC=7 -> instr 7 delivered, HALTED=1, PC_OUT=8 held 10 cycles, IMEM_REQ=0; HLT=0 -> IMEM_ADDR=8.
REQ-032 PC_OUT=0xFFFF_FFFF fetched -> PC_OUT wraps to 0x0000_0000.
REQ-033 RST_N=0 mid-WAIT then RVALID after release -> ignored; first fetch at RESET_PC.
REQ-034 With FETCH_SEQ_IRQ_EN, IRQ=1 in REQ at PC=0x20 -> EPC=0x20, IRQ_ACK one cycle, IMEM_ADDR=0x40.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg
//   Shared definitions for the fetch sequencer: FSM state encoding and the
//   default values of the PC reset value, sequential step and interrupt vector.
package fetch_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HALT = 2'd3
   } fetch_state_e;

   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DEF_PC_INC     = 32'h0000_0001;
   localparam logic [31:0] DEF_IRQ_VECTOR = 32'h0000_0040;

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg
//   Program counter register. A load takes precedence over an increment;
//   the increment wraps modulo 2^ADDR_W.
//
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset (pc_o <= RESET_PC)
//   load_en_i    load load_val_i into the PC
//   load_val_i   value to load
//   inc_en_i     advance the PC by PC_INC
//   pc_o         current PC
module fetch_pc_reg #(
   parameter int unsigned           ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]     RESET_PC = '0,
   parameter logic [ADDR_W-1:0]     PC_INC   = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              load_en_i,
   input  logic [ADDR_W-1:0] load_val_i,
   input  logic              inc_en_i,
   output logic [ADDR_W-1:0] pc_o
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_en_i) begin
         pc_d = load_val_i;
      end else if (inc_en_i) begin
         pc_d = pc_q + PC_INC;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction fetch sequencer with at most one outstanding memory
//   transaction. Handles branch redirects (dropping an in-flight response),
//   halt requests and, optionally, an interrupt redirect.
//
//   Optional feature macro: FETCH_SEQ_IRQ_EN (adds irq_i, irq_ack_o, epc_o
//   and the IRQ_VECTOR parameter).
//
//   clk_i / rst_n_i           clock / async active-low reset
//   hlt_i                     halt request (level)
//   br_taken_i, br_target_i   redirect strobe and target
//   imem_req_o, imem_addr_o   memory request and address
//   imem_gnt_i                request accepted
//   imem_rvalid_i, imem_rdata_i  response strobe and data
//   instr_valid_o, instr_o, instr_pc_o  delivered instruction (one-cycle pulse)
//   pc_out_o                  current PC
//   halted_o                  sequencer is in HALT
//   irq_i, irq_ack_o, epc_o   interrupt request / acknowledge / saved PC
//
//   state | meaning
//   IDLE  | one cycle after reset release
//   REQ   | request asserted at pc_out_o, waiting for grant
//   WAIT  | granted, waiting for the response
//   HALT  | stopped, no requests, PC frozen
module fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
   parameter logic [ADDR_W-1:0] PC_INC     = ADDR_W'(DEF_PC_INC)
`ifdef FETCH_SEQ_IRQ_EN
   ,
   parameter logic [ADDR_W-1:0] IRQ_VECTOR = ADDR_W'(DEF_IRQ_VECTOR)
`endif
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              hlt_i,
   input  logic              br_taken_i,
   input  logic [ADDR_W-1:0] br_target_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_gnt_i,
   input  logic              imem_rvalid_i,
   input  logic [31:0]       imem_rdata_i,
   output logic              instr_valid_o,
   output logic [31:0]       instr_o,
   output logic [ADDR_W-1:0] instr_pc_o,
   output logic [ADDR_W-1:0] pc_out_o,
   output logic              halted_o
`ifdef FETCH_SEQ_IRQ_EN
   ,
   input  logic              irq_i,
   output logic              irq_ack_o,
   output logic [ADDR_W-1:0] epc_o
`endif
);

   fetch_state_e      state_q, state_d;
   logic              drop_q, drop_d;
   logic              ivalid_q, ivalid_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;
   logic              pc_load, pc_inc;
   logic [ADDR_W-1:0] pc_load_val;
   logic [ADDR_W-1:0] pc;
   logic              irq_take;
   logic              gnt;

`ifdef FETCH_SEQ_IRQ_EN
   logic              irq_ack_q, irq_ack_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   // A branch outranks the interrupt, so only an unbranched IRQ is taken.
   assign irq_take = irq_i && !br_taken_i;
`else
   assign irq_take = 1'b0;
`endif

   fetch_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC),
      .PC_INC   (PC_INC)
   ) u_pc (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load_en_i  (pc_load),
      .load_val_i (pc_load_val),
      .inc_en_i   (pc_inc),
      .pc_o       (pc)
   );

   // Halt and interrupt are decided before a grant can be accepted, so the
   // request is withheld in those cycles.
   assign imem_req_o = (state_q == ST_REQ) && !hlt_i && !irq_take;
   assign gnt        = imem_req_o && imem_gnt_i;

   always_comb begin
      state_d     = state_q;
      drop_d      = drop_q;
      ivalid_d    = 1'b0;
      instr_d     = instr_q;
      ipc_d       = ipc_q;
      pc_load     = 1'b0;
      pc_inc      = 1'b0;
      pc_load_val = br_target_i;
`ifdef FETCH_SEQ_IRQ_EN
      irq_ack_d   = 1'b0;
      epc_d       = epc_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (br_taken_i) begin
               pc_load = 1'b1;
               if (gnt) begin
                  drop_d  = 1'b1;
                  state_d = ST_WAIT;
               end
            end else if (irq_take) begin
`ifdef FETCH_SEQ_IRQ_EN
               pc_load     = 1'b1;
               pc_load_val = IRQ_VECTOR;
               epc_d       = pc;
               irq_ack_d   = 1'b1;
`endif
            end else if (hlt_i) begin
               state_d = ST_HALT;
            end else if (gnt) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (br_taken_i) begin
               pc_load = 1'b1;
               if (imem_rvalid_i) begin
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (imem_rvalid_i) begin
               if (!drop_q) begin
                  ivalid_d = 1'b1;
                  instr_d  = imem_rdata_i;
                  ipc_d    = pc;
                  pc_inc   = 1'b1;
               end
               drop_d  = 1'b0;
               state_d = hlt_i ? ST_HALT : ST_REQ;
            end
         end
         ST_HALT: begin
            if (!hlt_i) begin
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         drop_q   <= 1'b0;
         ivalid_q <= 1'b0;
         instr_q  <= '0;
         ipc_q    <= '0;
      end else begin
         state_q  <= state_d;
         drop_q   <= drop_d;
         ivalid_q <= ivalid_d;
         instr_q  <= instr_d;
         ipc_q    <= ipc_d;
      end
   end

`ifdef FETCH_SEQ_IRQ_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         irq_ack_q <= 1'b0;
         epc_q     <= '0;
      end else begin
         irq_ack_q <= irq_ack_d;
         epc_q     <= epc_d;
      end
   end

   assign irq_ack_o = irq_ack_q;
   assign epc_o     = epc_q;
`endif

   assign imem_addr_o   = pc;
   assign pc_out_o      = pc;
   assign instr_valid_o = ivalid_q;
   assign instr_o       = instr_q;
   assign instr_pc_o    = ipc_q;
   assign halted_o      = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n_i;
   logic        hlt_i;
   logic        br_taken_i;
   logic [31:0] br_target_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic [31:0] pc_out_o;
   logic        halted_o;
`ifdef FETCH_SEQ_IRQ_EN
   logic        irq_i;
   logic        irq_ack_o;
   logic [31:0] epc_o;
`endif

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];
   bit   auto_mem;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n_i),
      .hlt_i         (hlt_i),
      .br_taken_i    (br_taken_i),
      .br_target_i   (br_target_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .pc_out_o      (pc_out_o),
      .halted_o      (halted_o)
`ifdef FETCH_SEQ_IRQ_EN
      ,
      .irq_i         (irq_i),
      .irq_ack_o     (irq_ack_o),
      .epc_o         (epc_o)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc);
      exp_t e;
      e.instr = instr;
      e.pc    = pc;
      sb.push_back(e);
   endtask

   // One clock: capture the handshake before the edge, then after the edge
   // compare any delivered instruction against the scoreboard and, in
   // auto mode, answer the last grant one cycle later.
   task automatic tick();
      logic        granted;
      logic [31:0] gaddr;
      exp_t        e;
      granted = imem_req_o && imem_gnt_i && rst_n_i;
      gaddr   = imem_addr_o;
      @(posedge clk);
      #1;
      if (instr_valid_o) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", {31'd0, instr_valid_o}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("instr", instr_o, e.instr);
            chk("instr_pc", instr_pc_o, e.pc);
         end
      end
      if (auto_mem) begin
         imem_rvalid_i = granted;
         imem_rdata_i  = 32'hA0 + gaddr;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n_i       = 1'b0;
      hlt_i         = 1'b0;
      br_taken_i    = 1'b0;
      br_target_i   = '0;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      auto_mem      = 1'b1;
`ifdef FETCH_SEQ_IRQ_EN
      irq_i         = 1'b0;
`endif
      ticks(3);
      chk("rst_pc", pc_out_o, 32'h0);
      chk("rst_req", {31'd0, imem_req_o}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_instr_pc", instr_pc_o, 32'h0);
      chk("rst_halted", {31'd0, halted_o}, 32'd0);

      // Release: IDLE for one cycle, then REQ at RESET_PC.
      rst_n_i = 1'b1;
      #1;
      chk("idle_req", {31'd0, imem_req_o}, 32'd0);
      tick();
      chk("first_req", {31'd0, imem_req_o}, 32'd1);
      chk("first_addr", imem_addr_o, 32'h0);

      // Three back-to-back fetches at one instruction per two cycles.
      push(32'hA0, 32'd0);
      push(32'hA1, 32'd1);
      push(32'hA2, 32'd2);
      imem_gnt_i = 1'b1;
      ticks(5);
      imem_gnt_i = 1'b0;
      tick();
      chk("seq_pc", pc_out_o, 32'd3);
      chk("seq_addr", imem_addr_o, 32'd3);

      // Redirect in REQ without grant, then redirect in WAIT (drop flag).
      auto_mem      = 1'b0;
      imem_rvalid_i = 1'b0;
      br_taken_i    = 1'b1;
      br_target_i   = 32'd5;
      tick();
      chk("br_req_pc", pc_out_o, 32'd5);
      chk("br_req_addr", imem_addr_o, 32'd5);
      br_taken_i = 1'b0;
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i  = 1'b0;
      br_taken_i  = 1'b1;
      br_target_i = 32'h100;
      tick();
      chk("br_wait_pc", pc_out_o, 32'h100);
      chk("br_wait_req", {31'd0, imem_req_o}, 32'd0);
      br_taken_i    = 1'b0;
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_0005;
      tick();
      imem_rvalid_i = 1'b0;
      chk("drop_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("drop_addr", imem_addr_o, 32'h100);
      chk("drop_req", {31'd0, imem_req_o}, 32'd1);

      // Redirect coinciding with the response: target wins over +PC_INC.
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_0100;
      br_taken_i    = 1'b1;
      br_target_i   = 32'h200;
      tick();
      imem_rvalid_i = 1'b0;
      br_taken_i    = 1'b0;
      chk("br_rv_pc", pc_out_o, 32'h200);
      chk("br_rv_valid", {31'd0, instr_valid_o}, 32'd0);

      // Redirect in the same cycle as the grant.
      imem_gnt_i  = 1'b1;
      br_taken_i  = 1'b1;
      br_target_i = 32'h300;
      tick();
      imem_gnt_i    = 1'b0;
      br_taken_i    = 1'b0;
      chk("br_gnt_pc", pc_out_o, 32'h300);
      chk("br_gnt_wait_req", {31'd0, imem_req_o}, 32'd0);
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_0200;
      tick();
      imem_rvalid_i = 1'b0;
      chk("br_gnt_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("br_gnt_addr", imem_addr_o, 32'h300);

      // Halt raised in WAIT at PC 7: instruction 7 delivered, then HALT.
      br_taken_i  = 1'b1;
      br_target_i = 32'd7;
      tick();
      br_taken_i = 1'b0;
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i    = 1'b0;
      hlt_i         = 1'b1;
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'h0000_0077;
      push(32'h77, 32'd7);
      tick();
      imem_rvalid_i = 1'b0;
      chk("halt_halted", {31'd0, halted_o}, 32'd1);
      chk("halt_pc", pc_out_o, 32'd8);
      for (int i = 0; i < 10; i++) begin
         br_taken_i  = (i % 2 == 0);
         br_target_i = 32'h500;
         tick();
         chk("halt_hold_halted", {31'd0, halted_o}, 32'd1);
         chk("halt_hold_req", {31'd0, imem_req_o}, 32'd0);
         chk("halt_hold_pc", pc_out_o, 32'd8);
      end
      chk("hold_instr", instr_o, 32'h77);
      chk("hold_instr_pc", instr_pc_o, 32'd7);
      br_taken_i = 1'b0;
      hlt_i      = 1'b0;
      tick();
      chk("resume_addr", imem_addr_o, 32'd8);
      chk("resume_req", {31'd0, imem_req_o}, 32'd1);
      chk("resume_halted", {31'd0, halted_o}, 32'd0);

      // Halt in REQ before grant: request withdrawn, straight to HALT.
      hlt_i      = 1'b1;
      imem_gnt_i = 1'b1;
      #1;
      chk("hlt_req_masked", {31'd0, imem_req_o}, 32'd0);
      tick();
      chk("hlt_req_halted", {31'd0, halted_o}, 32'd1);
      hlt_i      = 1'b0;
      imem_gnt_i = 1'b0;
      tick();
      chk("hlt_req_resume", imem_addr_o, 32'd8);

      // PC wrap at all-ones.
      br_taken_i  = 1'b1;
      br_target_i = 32'hFFFF_FFFF;
      tick();
      br_taken_i = 1'b0;
      auto_mem   = 1'b1;
      push(32'h0000_009F, 32'hFFFF_FFFF);
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i = 1'b0;
      tick();
      chk("wrap_pc", pc_out_o, 32'h0);
      chk("wrap_addr", imem_addr_o, 32'h0);

      // Reset in WAIT; a late response after release is ignored.
      auto_mem      = 1'b0;
      imem_rvalid_i = 1'b0;
      br_taken_i    = 1'b1;
      br_target_i   = 32'h10;
      tick();
      br_taken_i = 1'b0;
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i = 1'b0;
      rst_n_i    = 1'b0;
      #1;
      chk("midrst_pc", pc_out_o, 32'h0);
      chk("midrst_req", {31'd0, imem_req_o}, 32'd0);
      tick();
      rst_n_i       = 1'b1;
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hBAD0_0010;
      #1;
      chk("midrst_idle_req", {31'd0, imem_req_o}, 32'd0);
      tick();
      chk("late_rv_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("late_rv_addr", imem_addr_o, 32'h0);
      tick();
      chk("late_rv_valid2", {31'd0, instr_valid_o}, 32'd0);
      chk("late_rv_instr", instr_o, 32'h0);
      imem_rvalid_i = 1'b0;
      auto_mem      = 1'b1;
      push(32'hA0, 32'd0);
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i = 1'b0;
      tick();
      chk("post_rst_pc", pc_out_o, 32'd1);

`ifdef FETCH_SEQ_IRQ_EN
      // Interrupt in REQ before grant.
      br_taken_i  = 1'b1;
      br_target_i = 32'h20;
      tick();
      br_taken_i = 1'b0;
      irq_i      = 1'b1;
      tick();
      irq_i = 1'b0;
      chk("irq_ack", {31'd0, irq_ack_o}, 32'd1);
      chk("irq_epc", epc_o, 32'h20);
      chk("irq_addr", imem_addr_o, 32'h40);
      tick();
      chk("irq_ack_pulse", {31'd0, irq_ack_o}, 32'd0);
      chk("irq_req", {31'd0, imem_req_o}, 32'd1);
`endif

      chk("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
